// File: rtl/display_pkg.sv
// Shared types and the seven-segment lookup for the DE2 hex display stage.
package display_pkg;

    typedef enum logic {
        EMPTY,
        SHOW
    } state_e;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low segments, bit order gfedcba.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            4'hF:    seg = 7'b0001110;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/display_fifo.sv
// Synchronous word FIFO with combinational head read; pointers wrap modulo DEPTH.
module display_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [AW:0]      count_q;

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + AW'(1);
            if (pop)  rptr_q <= rptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign rdata = mem_q[rptr_q];
    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/hex_display_unit.sv
// Buffers incoming 32-bit words and shows each on HEX7..HEX0 for a fixed dwell time.
module hex_display_unit
    import display_pkg::*;
#(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned DWELL_CYCLES = 50_000_000
) (
    input  logic        clk_hifreq,
    input  logic        rst_n,
    input  logic        valid,
    input  logic [31:0] data_in,
    output logic        ready,
    output logic [6:0]  hex0,
    output logic [6:0]  hex1,
    output logic [6:0]  hex2,
    output logic [6:0]  hex3,
    output logic [6:0]  hex4,
    output logic [6:0]  hex5,
    output logic [6:0]  hex6,
    output logic [6:0]  hex7,
    output logic        busy
);

    localparam int unsigned DW = $clog2(DWELL_CYCLES);
    localparam logic [DW-1:0] DWELL_MAX = DW'(DWELL_CYCLES - 1);
    localparam logic [$clog2(DEPTH):0] FULL_CNT = DEPTH[$clog2(DEPTH):0];

    logic                  push, pop;
    logic [31:0]           fifo_rdata;
    logic                  fifo_full, fifo_empty;
    logic [$clog2(DEPTH):0] fifo_count;

    state_e        state_q, state_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [31:0]   disp_q, disp_d;
    logic          busy_q;
    logic [6:0]    seg_q [8];

    assign ready = (fifo_count != FULL_CNT);
    assign push  = valid && ready;

    display_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk   (clk_hifreq),
        .rst_n (rst_n),
        .push  (push),
        .wdata (data_in),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        state_d = state_q;
        dwell_d = dwell_q;
        disp_d  = disp_q;
        pop     = 1'b0;
        case (state_q)
            EMPTY: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    disp_d  = fifo_rdata;
                    dwell_d = '0;
                    state_d = SHOW;
                end
            end
            SHOW: begin
                // Expired dwell with nothing queued: hold the last word until one arrives.
                if (dwell_q == DWELL_MAX) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        disp_d  = fifo_rdata;
                        dwell_d = '0;
                    end
                end else begin
                    dwell_d = dwell_q + DW'(1);
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk_hifreq) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            dwell_q <= '0;
            disp_q  <= '0;
            busy_q  <= 1'b0;
            for (int unsigned i = 0; i < 8; i++) seg_q[i] <= SEG_BLANK;
        end else begin
            state_q <= state_d;
            dwell_q <= dwell_d;
            disp_q  <= disp_d;
            busy_q  <= (state_d == SHOW) && (dwell_d != DWELL_MAX);
            for (int unsigned i = 0; i < 8; i++)
                seg_q[i] <= (state_q == SHOW) ? hex_to_seg(disp_q[4*i +: 4]) : SEG_BLANK;
            assert (!(push && fifo_full));
        end
    end

    assign busy = busy_q;
    assign hex0 = seg_q[0];
    assign hex1 = seg_q[1];
    assign hex2 = seg_q[2];
    assign hex3 = seg_q[3];
    assign hex4 = seg_q[4];
    assign hex5 = seg_q[5];
    assign hex6 = seg_q[6];
    assign hex7 = seg_q[7];

endmodule

// File: doc/hex_display_unit.md
# hex_display_unit

Display stage for the DE2 test environment. Accepts 32-bit words over a valid/ready handshake from the RAM-readout test stage and buffers them in a small FIFO. Shows each word as eight hexadecimal digits on the board's eight seven-segment displays (HEX7..HEX0) for a fixed dwell time, then advances to the next buffered word.

## Interface
Parameters:
- DEPTH, 4: FIFO depth in words. Power of two, ≥ 2.
- DWELL_CYCLES, 50_000_000: clk_hifreq cycles each word is shown. ≥ 2.

Ports:
- clk_hifreq, input, 1: single clock for all logic.
- rst_n, input, 1: reset, synchronous and active-low.
- valid, input, 1: upstream word present on data_in.
- data_in, input, 32: word to display.
- ready, output, 1: unit can accept a word this cycle.
- hex0..hex7, output, 7 each: active-low segments, bit order gfedcba. hex0 shows nibble data[3:0]; hex7 shows nibble data[31:28].
- busy, output, 1: a word is displayed and its dwell has not yet expired.

## Operation
**Handshake**
- A word is accepted on a rising edge where valid && ready.
- ready = (fifo count != DEPTH). It is driven from registered count only and never depends on valid.
- Upstream holds data_in stable while valid && !ready. The unit makes no other assumption about valid.

**FIFO**
- Synchronous FIFO, DEPTH entries, pointers wrap modulo DEPTH.
- Push and pop on the same edge leave count unchanged and both pointers advance.
- No push is possible when full, because ready is low. A pop is never issued when empty.

**State machine** (states: EMPTY, SHOW)
- EMPTY: displays are blank and busy = 0. If count != 0, pop the head into disp_word, clear dwell_cnt, and go to SHOW.
- SHOW: dwell_cnt increments each cycle and saturates at DWELL_CYCLES-1.
  - When dwell_cnt == DWELL_CYCLES-1 and count != 0: pop the next word into disp_word and clear dwell_cnt. The display changes on the next edge.
  - When dwell_cnt == DWELL_CYCLES-1 and count == 0: keep showing the last word indefinitely. A later arrival is popped one cycle after it becomes visible in the FIFO.
- busy = (state == SHOW) && (dwell_cnt != DWELL_CYCLES-1).
- The unit never returns to EMPTY except through reset. The last word stays on display.

**Decode**
- Registered nibble-to-segment lookup, one per digit, computed from disp_word.
- Encodings:
  - 0: 1000000
  - 1: 1111001
  - 2: 0100100
  - 3: 0110000
  - 4: 0011001
  - 5: 0010010
  - 6: 0000010
  - 7: 1111000
  - 8: 0000000
  - 9: 0010000
  - A: 0001000
  - b: 0000011
  - C: 1000110
  - d: 0100001
  - E: 0000110
  - F: 0001110
- Blank encoding: 1111111.

## Timing
**Reset** (rst_n = 0 sampled on an edge)
- State becomes EMPTY; count, pointers, dwell_cnt and disp_word are cleared.
- All hexN = 7'h7F, busy = 0, ready = 1 from the following cycle.
- A mid-operation reset discards buffered words and the displayed word. A word presented during the reset cycle is not accepted.

**Latency**
- A word accepted at edge E0 into an empty unit is loaded into disp_word at E1. The segments show it after E2.
- Each word is shown for exactly DWELL_CYCLES cycles when successors are already queued.

**Throughput**
- Sustained acceptance is one word per DWELL_CYCLES once the FIFO fills. Bursts of up to DEPTH words (plus the one being displayed) are accepted back-to-back.

## Structure
- Package display_pkg holds:
  - the state enum (EMPTY, SHOW);
  - SEG_BLANK = 7'h7F;
  - function hex_to_seg(logic [3:0]) returning logic [6:0].
- Sub-module display_fifo holds the synchronous FIFO (parameter DEPTH, WIDTH=32, outputs full/empty/count). hex_display_unit instantiates it once.
- The dwell counter width is $clog2(DWELL_CYCLES).

## Test plan
All scenarios use DEPTH=4, DWELL_CYCLES=4.
- **Reset:** hold rst_n=0 for 2 cycles → hex0..hex7 = 7'h7F, busy=0, ready=1.
- **Single word:** one-cycle valid with 0x0123_4567 at edge E0 → after E2, hex0=1111000 ('7') … hex7=1000000 ('0'); busy=1 for 3 cycles, then 0; display holds.
- **Burst:** valid held with 6 words 0xA0..0xA5 → ready drops after the FIFO holds 4 words. Each word is shown for exactly 4 cycles in order. No word is lost or duplicated, and ready returns high as pops occur.
- **Stall:** valid=1 while ready=0 → no acceptance and count stays at 4. The word is accepted on the first edge after ready rises.
- **Late arrival:** let the dwell expire with the FIFO empty, then push 0xDEAD_BEEF → it is displayed 2 cycles after acceptance, and hex7..hex0 show d,E,A,d,b,E,E,F.
- **Mid-burst reset:** assert rst_n=0 while 3 words are queued → displays blank and no queued word appears after reset is released.
